// File: rtl/gray_seq_ctrl.sv
// Sequencing controller for a Gray-code counter datapath.
// Holds the binary count internally and drives a registered Gray output.
module gray_seq_ctrl #(
    parameter int SIZE = 4,
    parameter int INC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            pause,
    input  logic            clear,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic [SIZE-1:0] term_val,
    input  logic            cont,
    output logic [SIZE-1:0] gray,
    output logic            busy,
    output logic            done,
    output logic            tc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Step size reduced modulo 2^SIZE.
    localparam logic [SIZE-1:0] INC_V = SIZE'(INC);

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] bin_q;
    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] bin_inc;
    logic [SIZE-1:0] gray_q;
    logic [SIZE-1:0] gray_d;
    logic            tc_q;
    logic            tc_d;
    logic            at_term;

    // Incremented count; the natural wrap is silent.
    assign bin_inc = bin_q + INC_V;

    // Exact-match terminal detection against the live term_val.
    assign at_term = (bin_q == term_val);

    // Next state, next count and terminal pulse; clear beats load beats FSM.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        tc_d    = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            bin_d   = '0;
        end else if (load) begin
            bin_d   = load_val;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_HOLD;
                    end else if (at_term) begin
                        tc_d = 1'b1;
                        if (cont) begin
                            bin_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bin_d = bin_inc;
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_RUN;
                        bin_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Gray image of the next count, so gray tracks bin in the same cycle.
    assign gray_d = bin_d ^ (bin_d >> 1);

    // State, count, Gray and terminal-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            tc_q    <= tc_d;
        end
    end

    // Status outputs decoded from the registered state only.
    assign busy = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done = (state_q == S_DONE);
    assign gray = gray_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: directed test-plan scenarios
// followed by randomized control traffic against a behavioural model.
module tb_gray_seq_ctrl;

    localparam int SIZE = 4;
    localparam int INC  = 1;
    localparam int MOD  = 1 << SIZE;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            pause;
    logic            clear;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic [SIZE-1:0] term_val;
    logic            cont;
    logic [SIZE-1:0] gray;
    logic            busy;
    logic            done;
    logic            tc;

    gray_seq_ctrl #(.SIZE(SIZE), .INC(INC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .term_val (term_val),
        .cont     (cont),
        .gray     (gray),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
    );

    typedef struct {
        int g;
        int b;
        int d;
        int t;
    } exp_t;

    exp_t  exp_q[$];
    int    ntests = 0;
    int    nerr   = 0;

    // Behavioural model: a mode name and an integer count.
    string m_mode;
    int    m_cnt;
    int    m_tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, int act, int req);
        ntests++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic int to_gray(int v);
        return (v ^ (v >> 1)) % MOD;
    endfunction

    function void model_reset();
        m_mode = "IDLE";
        m_cnt  = 0;
        m_tc   = 0;
    endfunction

    function void model_step();
        m_tc = 0;
        if (clear) begin
            m_mode = "IDLE";
            m_cnt  = 0;
        end else if (load) begin
            m_cnt = int'(load_val);
        end else if (m_mode == "IDLE") begin
            if (start) m_mode = "RUN";
        end else if (m_mode == "RUN") begin
            if (pause) begin
                m_mode = "HOLD";
            end else if (m_cnt == int'(term_val)) begin
                m_tc = 1;
                if (cont) m_cnt = 0;
                else m_mode = "DONE";
            end else begin
                m_cnt = (m_cnt + INC) % MOD;
            end
        end else if (m_mode == "HOLD") begin
            if (!pause) m_mode = "RUN";
        end else if (m_mode == "DONE") begin
            if (start) begin
                m_mode = "RUN";
                m_cnt  = 0;
            end
        end
    endfunction

    // One clock: advance the model on the edge and queue what the DUT should show.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        e.g = to_gray(m_cnt);
        e.b = (m_mode == "RUN" || m_mode == "HOLD") ? 1 : 0;
        e.d = (m_mode == "DONE") ? 1 : 0;
        e.t = m_tc;
        exp_q.push_back(e);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(logic s, logic p, logic c, logic l,
                          logic [SIZE-1:0] lv, logic [SIZE-1:0] tv, logic ct);
        start    = s;
        pause    = p;
        clear    = c;
        load     = l;
        load_val = lv;
        term_val = tv;
        cont     = ct;
    endtask

    // Asynchronous reset between edges, then release and confirm IDLE.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("arst_gray", int'(gray), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_tc", int'(tc), 0);
        set_in(0, 0, 0, 0, '0, term_val, cont);
        ticks(2);
        #2;
        rst_n = 1'b1;
        ticks(3);
        chk("post_rst_idle", int'(busy), 0);
    endtask

    // Monitor: pop one expectation per clock and compare.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_gray", int'(gray), e.g);
            chk("sb_busy", int'(busy), e.b);
            chk("sb_done", int'(done), e.d);
            chk("sb_tc", int'(tc), e.t);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tcs;
        int busy_low;
        model_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, '0, 4'd5, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gray", int'(gray), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tc", int'(tc), 0);
        #2;
        rst_n = 1'b1;

        // One-shot to term_val=5.
        set_in(1, 0, 0, 0, '0, 4'd5, 0);
        tick();
        set_in(0, 0, 0, 0, '0, 4'd5, 0);
        ticks(5);
        chk("os_gray5", int'(gray), 4'b0111);
        tick();
        chk("os_tc", int'(tc), 1);
        chk("os_done", int'(done), 1);
        chk("os_busy", int'(busy), 0);
        tick();
        chk("os_tc_once", int'(tc), 0);
        chk("os_hold", int'(gray), 4'b0111);

        // Continuous full cycle.
        set_in(1, 0, 0, 0, '0, 4'd15, 1);
        tick();
        set_in(0, 0, 0, 0, '0, 4'd15, 1);
        tcs = 0;
        busy_low = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (tc) tcs++;
            if (!busy) busy_low++;
        end
        chk("cont_tcs", tcs, 2);
        chk("cont_busy", busy_low, 0);

        // Pause at gray 0011.
        set_in(0, 0, 1, 0, '0, 4'd15, 0);
        tick();
        set_in(1, 0, 0, 0, '0, 4'd15, 0);
        tick();
        set_in(0, 0, 0, 0, '0, 4'd15, 0);
        ticks(2);
        chk("pz_at", int'(gray), 4'b0011);
        set_in(0, 1, 0, 0, '0, 4'd15, 0);
        ticks(3);
        chk("pz_hold", int'(gray), 4'b0011);
        chk("pz_busy", int'(busy), 1);
        set_in(0, 0, 0, 0, '0, 4'd15, 0);
        ticks(2);
        chk("pz_next1", int'(gray), 4'b0010);
        tick();
        chk("pz_next2", int'(gray), 4'b0110);

        // Load in IDLE, run, then clear.
        set_in(0, 0, 1, 0, '0, 4'd15, 0);
        tick();
        set_in(0, 0, 0, 1, 4'd9, 4'd15, 0);
        tick();
        chk("ld_idle", int'(gray), 4'b1101);
        set_in(1, 0, 0, 0, '0, 4'd15, 0);
        tick();
        set_in(0, 0, 0, 0, '0, 4'd15, 0);
        ticks(2);
        set_in(0, 0, 1, 0, '0, 4'd15, 0);
        tick();
        chk("clr_gray", int'(gray), 0);
        chk("clr_busy", int'(busy), 0);

        // Clear beats load.
        set_in(0, 0, 1, 1, 4'd7, 4'd15, 0);
        tick();
        chk("clr_ld", int'(gray), 0);

        // Load during RUN at bin 3.
        set_in(1, 0, 0, 0, '0, 4'd15, 0);
        tick();
        set_in(0, 0, 0, 0, '0, 4'd15, 0);
        ticks(3);
        set_in(0, 0, 0, 1, 4'd12, 4'd15, 0);
        tick();
        chk("ld_run", int'(gray), 4'b1010);
        set_in(0, 0, 0, 0, '0, 4'd15, 0);
        tick();

        // Reset mid-run.
        mid_reset();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 199) == 0) mid_reset();
            start    = ($urandom_range(0, 7) == 0);
            pause    = ($urandom_range(0, 5) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = SIZE'($urandom);
            if ($urandom_range(0, 49) == 0) term_val = SIZE'($urandom);
            if ($urandom_range(0, 99) == 0) cont = ~cont;
        end
        set_in(0, 0, 0, 0, '0, term_val, cont);
        tick();
        repeat (2) @(negedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nerr);
        $finish;
    end

endmodule
